exe_stage: RTL

- Execute stage of the 5-stage MIPS pipeline, between the decode stage and the memory stage.
- Latches the decode-to-execute bus under the valid/allowin handshake and computes operands and the ALU result, through the existing `alu` module.
- Owns the HI/LO registers: single-cycle mult/multu, iterative div/divu, mfhi/mflo/mthi/mtlo.
- Issues data-SRAM requests and drives the execute-stage forwarding/block bus back to decode.

---
 rtl/exe_stage_pkg.sv | 55 +++++
 rtl/exe_stage_if.sv | 30 +++
 rtl/alu.sv | 26 ++
 rtl/exe_stage_div_iter.sv | 78 +++++++
 rtl/exe_stage.sv | 107 ++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared bus widths and packed bus layouts for the execute stage.
// Field order in every struct matches the bit positions used by decode and memory.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 145;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_FWD_BUS_WD   = 39;
  localparam int DIV_CYCLES_DEF  = 33;

  typedef struct packed {
    logic        mult;
    logic        multu;
    logic        div;
    logic        divu;
    logic        mfhi;
    logic        mflo;
    logic        mthi;
    logic        mtlo;
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_uimm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_bus_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] es_result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic        es_load;
    logic        es_block_valid;
    logic [4:0]  es_dest;
    logic [31:0] es_res;
  } es_fwd_bus_t;

  // Two's-complement magnitude when neg is set, pass-through otherwise.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Decode/execute/memory handshake, forwarding and data-SRAM request signals.
// master = execute stage, slave = its neighbours.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_wen;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;

  modport master (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/alu.sv
// One-hot ALU: add sub slt sltu and nor or xor sll srl sra lui (op bits 0..11).
// Purely combinational; no backpressure.
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  always_comb begin
    alu_result = 32'h0;
    if (alu_op[0])       alu_result = alu_src1 + alu_src2;
    else if (alu_op[1])  alu_result = alu_src1 - alu_src2;
    else if (alu_op[2])  alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
    else if (alu_op[3])  alu_result = {31'b0, alu_src1 < alu_src2};
    else if (alu_op[4])  alu_result = alu_src1 & alu_src2;
    else if (alu_op[5])  alu_result = ~(alu_src1 | alu_src2);
    else if (alu_op[6])  alu_result = alu_src1 | alu_src2;
    else if (alu_op[7])  alu_result = alu_src1 ^ alu_src2;
    else if (alu_op[8])  alu_result = alu_src2 << alu_src1[4:0];
    else if (alu_op[9])  alu_result = alu_src2 >> alu_src1[4:0];
    else if (alu_op[10]) alu_result = $signed(alu_src2) >>> alu_src1[4:0];
    else if (alu_op[11]) alu_result = {alu_src2[15:0], 16'h0};
  end

endmodule

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring divider on magnitudes with sign fix-up; divisor 0 gives q=all-ones, r=dividend.
// Latency DIV_CYCLES from start to a one-cycle done pulse; results held until next start.
module div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [4:0] LAST = 5'(DIV_CYCLES - 2);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dvs_q, raw_q;
  logic        neg_q, neg_r, dz;
  logic [32:0] rem_sh, diff;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;

  // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = !diff[32];
    rem_nx = ge ? diff[31:0] : rem_sh[31:0];
    quo_nx = {quo_q[30:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      raw_q     <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        cnt   <= 5'd0;
        rem_q <= 32'd0;
        quo_q <= mag(dividend, is_signed && dividend[31]);
        dvs_q <= mag(divisor, is_signed && divisor[31]);
        neg_q <= is_signed && (dividend[31] ^ divisor[31]);
        neg_r <= is_signed && dividend[31];
        dz    <= (divisor == 32'd0);
        raw_q <= dividend;
      end else if (busy) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + 5'd1;
        if (cnt == LAST) begin
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= dz ? 32'hFFFF_FFFF : mag(quo_nx, neg_q);
          remainder <= dz ? raw_q : mag(rem_nx, neg_r);
        end
      end
    end
  end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand select, ALU, HI/LO (mult, iterative div, mt*/mf*), SRAM request, forwarding.
// One cycle per instruction, div stalls DIV_CYCLES; holds while ms_allowin is low via es_allowin.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  exe_stage_if.master bus
);

  ds_to_es_bus_t r;
  es_to_ms_bus_t ms_bus;
  es_fwd_bus_t   fwd;
  logic          es_valid, es_ready_go, es_allowin, retire;
  logic          div_started, done_seen, div_start, div_done, is_div;
  logic [31:0]   hi, lo, src1, src2, alu_result, es_result, div_q, div_r;
  logic [63:0]   prod_s, prod_u;

  assign is_div      = r.div | r.divu;
  assign es_ready_go = !is_div || div_done || done_seen;
  assign es_allowin  = !es_valid || (es_ready_go && bus.ms_allowin);
  assign retire      = es_valid && es_ready_go && bus.ms_allowin;
  assign div_start   = es_valid && is_div && !div_started;

  always_comb begin
    src1 = r.src1_is_sa ? {27'b0, r.imm[10:6]} :
           r.src1_is_pc ? r.pc : r.rs_value;
    src2 = r.src2_is_imm  ? {{16{r.imm[15]}}, r.imm} :
           r.src2_is_uimm ? {16'b0, r.imm} :
           r.src2_is_8    ? 32'd8 : r.rt_value;
  end

  alu u_alu (
    .alu_op    (r.alu_op),
    .alu_src1  (src1),
    .alu_src2  (src2),
    .alu_result(alu_result)
  );

  // Low 64 bits of a 64x64 product of extended operands give the exact 32x32 result.
  assign prod_s = {{32{r.rs_value[31]}}, r.rs_value} * {{32{r.rt_value[31]}}, r.rt_value};
  assign prod_u = {32'b0, r.rs_value} * {32'b0, r.rt_value};

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .is_signed(r.div),
    .dividend (r.rs_value),
    .divisor  (r.rt_value),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r)
  );

  assign es_result = r.mfhi ? hi : r.mflo ? lo : alu_result;

  always_comb begin
    ms_bus.res_from_mem = r.load_op;
    ms_bus.gr_we        = r.gr_we;
    ms_bus.dest         = r.dest;
    ms_bus.es_result    = es_result;
    ms_bus.pc           = r.pc;
    fwd.es_load         = es_valid && r.load_op;
    fwd.es_block_valid  = es_valid && r.gr_we;
    fwd.es_dest         = r.dest;
    fwd.es_res          = es_result;
  end

  assign bus.es_allowin      = es_allowin;
  assign bus.es_to_ms_valid  = es_valid && es_ready_go;
  assign bus.es_to_ms_bus    = ms_bus;
  assign bus.es_fwd_bus      = fwd;
  assign bus.data_sram_en    = es_valid && (r.load_op || r.mem_we);
  assign bus.data_sram_wen   = {4{es_valid && r.mem_we}};
  assign bus.data_sram_addr  = alu_result;
  assign bus.data_sram_wdata = r.rt_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid    <= 1'b0;
      r           <= '0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_started <= 1'b0;
      done_seen   <= 1'b0;
    end else begin
      if (es_allowin) es_valid <= bus.ds_to_es_valid;
      if (bus.ds_to_es_valid && es_allowin) r <= bus.ds_to_es_bus;
      if (div_start) div_started <= 1'b1;
      if (div_done)  done_seen   <= 1'b1;
      // HI/LO commit only on retire so a stalled instruction writes once.
      if (retire) begin
        div_started <= 1'b0;
        done_seen   <= 1'b0;
        if (r.mult)                {hi, lo} <= prod_s;
        else if (r.multu)          {hi, lo} <= prod_u;
        else if (is_div)           begin lo <= div_q; hi <= div_r; end
        else if (r.mthi)           hi <= r.rs_value;
        else if (r.mtlo)           lo <= r.rs_value;
      end
    end
  end

endmodule
